ysyx_24100006_aclint: RTL and testbench

//  AXI-Lite slave CLINT for NHART harts: free-running 64-bit mtime, per-hart mtimecmp and msip.

---
 rtl/ysyx_24100006_aclint.sv | 356 +++++++++++++++++++++++++++++++++++
 tb/tb_ysyx_24100006_aclint.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100006_aclint.sv
// ---------------------------------------------------------------------------
// ysyx_24100006_aclint
//
// AXI-Lite slave CLINT serving NHART harts. Holds a free-running 64-bit
// mtime, one 64-bit mtimecmp and one msip bit per hart, and drives
// registered timer (mtip) and software (msip) interrupt lines.
//
// Parameters
//   BASE_ADDR  region base address; all register offsets are relative to it
//   NHART      number of harts served (1..8)
//   TICK_DIV   clk cycles per mtime increment (>=1)
//
// Ports
//   clk, reset             clock, asynchronous active-high reset
//   axi_ar* / axi_r*       AXI-Lite read address / read data channels
//   axi_aw* / axi_w*       AXI-Lite write address / write data channels
//   axi_b*                 AXI-Lite write response channel
//   mtip[NHART-1:0]        timer interrupt per hart (mtime >= mtimecmp)
//   msip[NHART-1:0]        software interrupt per hart
//
// Register map (offset from BASE_ADDR)
//   0x0000 + 4*h   msip[h]      bit 0 only, other bits read 0
//   0x4000 + 8*h   mtimecmp[h]  low word, +4 high word
//   0xBFF8/0xBFFC  mtime        low / high word
//   Anything else, h >= NHART, or a misaligned address -> SLVERR, rdata 0.
//
// Configuration macro
//   CLINT_MTIME_WR_EN  when defined, mtime is writable (byte strobes honoured,
//                      a write beats a same-cycle tick and clears the
//                      prescaler). When undefined, mtime writes complete with
//                      OKAY and are discarded.
// ---------------------------------------------------------------------------
module ysyx_24100006_aclint #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          NHART     = 1,
  parameter int          TICK_DIV  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      axi_araddr,
  input  logic             axi_arvalid,
  output logic             axi_arready,
  output logic             axi_rvalid,
  input  logic             axi_rready,
  output logic [31:0]      axi_rdata,
  output logic [1:0]       axi_rresp,
  output logic             axi_rlast,
  input  logic [31:0]      axi_awaddr,
  input  logic             axi_awvalid,
  output logic             axi_awready,
  input  logic [31:0]      axi_wdata,
  input  logic [3:0]       axi_wstrb,
  input  logic             axi_wvalid,
  output logic             axi_wready,
  output logic             axi_bvalid,
  input  logic             axi_bready,
  output logic [1:0]       axi_bresp,
  output logic [NHART-1:0] mtip,
  output logic [NHART-1:0] msip
);

  // Hart index width (at least one bit so NHART=1 still has a legal index).
  localparam int HW = (NHART > 1) ? $clog2(NHART) : 1;
  // Prescaler width and terminal count.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(TICK_DIV - 1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] K_MSIP  = 2'd0;
  localparam logic [1:0] K_CMP   = 2'd1;
  localparam logic [1:0] K_MTIME = 2'd2;
  localparam logic [1:0] K_NONE  = 2'd3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RADDR = 3'd1;
  localparam logic [2:0] S_RDATA = 3'd2;
  localparam logic [2:0] S_WADDR = 3'd3;
  localparam logic [2:0] S_WRESP = 3'd4;

  typedef struct packed {
    logic          valid;
    logic [1:0]    kind;
    logic          hi;
    logic [HW-1:0] hart;
  } dec_t;

  // Address decode: classifies an AXI address into register kind, hart and
  // word half. Hart range is checked on the full index before truncation.
  function automatic dec_t decode(input logic [31:0] addr);
    logic [31:0] off;
    dec_t        d;
    off     = addr - BASE_ADDR;
    d.valid = 1'b0;
    d.kind  = K_NONE;
    d.hi    = 1'b0;
    d.hart  = '0;
    if (addr[1:0] != 2'b00) begin
      d.valid = 1'b0;
    end else if (off < 32'h0000_0020) begin
      d.kind  = K_MSIP;
      d.hart  = off[2 +: HW];
      d.valid = ({29'd0, off[4:2]} < 32'(NHART));
    end else if ((off >= 32'h0000_4000) && (off < 32'h0000_4040)) begin
      d.kind  = K_CMP;
      d.hart  = off[3 +: HW];
      d.hi    = off[2];
      d.valid = ({29'd0, off[5:3]} < 32'(NHART));
    end else if (off == 32'h0000_BFF8) begin
      d.kind  = K_MTIME;
      d.valid = 1'b1;
    end else if (off == 32'h0000_BFFC) begin
      d.kind  = K_MTIME;
      d.hi    = 1'b1;
      d.valid = 1'b1;
    end else begin
      d.valid = 1'b0;
    end
    return d;
  endfunction

  // Byte-lane merge of a 32-bit write into an existing word.
  function automatic logic [31:0] merge32(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_w[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_w[8*b +: 8];
      end
    end
    return res;
  endfunction

  logic [2:0]       state_r;
  logic [31:0]      raddr_r;
  logic [31:0]      waddr_r;
  logic [31:0]      wdata_r;
  logic [3:0]       wstrb_r;
  logic             arready_r;
  logic             awready_r;
  logic             wready_r;
  logic             rvalid_r;
  logic [31:0]      rdata_r;
  logic [1:0]       rresp_r;
  logic             bvalid_r;
  logic [1:0]       bresp_r;

  logic [63:0]      mtime_r;
  logic [PW-1:0]    prescale_r;
  logic [63:0]      mtimecmp_r [NHART];
  logic [NHART-1:0] msip_r;
  logic [NHART-1:0] mtip_r;

  dec_t             rdec_s;
  dec_t             wdec_s;
  logic [31:0]      rd_val_s;
  logic             wr_act_s;
  logic             tick_s;

  // Decode latched addresses, form read data and write/tick strobes.
  always_comb begin
    rdec_s   = decode(raddr_r);
    wdec_s   = decode(waddr_r);
    rd_val_s = 32'd0;
    if (rdec_s.valid) begin
      case (rdec_s.kind)
        K_MSIP:  rd_val_s = {31'd0, msip_r[rdec_s.hart]};
        K_CMP:   rd_val_s = rdec_s.hi ? mtimecmp_r[rdec_s.hart][63:32]
                                      : mtimecmp_r[rdec_s.hart][31:0];
        K_MTIME: rd_val_s = rdec_s.hi ? mtime_r[63:32] : mtime_r[31:0];
        default: rd_val_s = 32'd0;
      endcase
    end else begin
      rd_val_s = 32'd0;
    end
    wr_act_s = (state_r == S_WADDR) && wdec_s.valid;
    tick_s   = (prescale_r == PS_MAX);
  end

  // Bus FSM: one read or one write in flight; a read wins a same-cycle tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= S_IDLE;
      raddr_r   <= 32'd0;
      waddr_r   <= 32'd0;
      wdata_r   <= 32'd0;
      wstrb_r   <= 4'd0;
      arready_r <= 1'b0;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= 32'd0;
      rresp_r   <= RESP_OKAY;
      bvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (axi_arvalid) begin
            arready_r <= 1'b1;
            raddr_r   <= axi_araddr;
            state_r   <= S_RADDR;
          end else if (axi_awvalid && axi_wvalid) begin
            awready_r <= 1'b1;
            wready_r  <= 1'b1;
            waddr_r   <= axi_awaddr;
            wdata_r   <= axi_wdata;
            wstrb_r   <= axi_wstrb;
            state_r   <= S_WADDR;
          end else begin
            state_r   <= S_IDLE;
          end
        end
        S_RADDR: begin
          arready_r <= 1'b0;
          rdata_r   <= rd_val_s;
          rresp_r   <= rdec_s.valid ? RESP_OKAY : RESP_SLVERR;
          rvalid_r  <= 1'b1;
          state_r   <= S_RDATA;
        end
        S_RDATA: begin
          if (axi_rready) begin
            rvalid_r <= 1'b0;
            state_r  <= S_IDLE;
          end else begin
            state_r  <= S_RDATA;
          end
        end
        S_WADDR: begin
          awready_r <= 1'b0;
          wready_r  <= 1'b0;
          bresp_r   <= wdec_s.valid ? RESP_OKAY : RESP_SLVERR;
          bvalid_r  <= 1'b1;
          state_r   <= S_WRESP;
        end
        S_WRESP: begin
          if (axi_bready) begin
            bvalid_r <= 1'b0;
            state_r  <= S_IDLE;
          end else begin
            state_r  <= S_WRESP;
          end
        end
        default: begin
          arready_r <= 1'b0;
          awready_r <= 1'b0;
          wready_r  <= 1'b0;
          rvalid_r  <= 1'b0;
          bvalid_r  <= 1'b0;
          state_r   <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CLINT_MTIME_WR_EN
  logic        mtime_wr_s;
  logic [63:0] mtime_wr_val_s;

  // Merge a software write into the half of mtime it targets.
  always_comb begin
    mtime_wr_s = wr_act_s && (wdec_s.kind == K_MTIME);
    if (wdec_s.hi) begin
      mtime_wr_val_s = {merge32(mtime_r[63:32], wdata_r, wstrb_r), mtime_r[31:0]};
    end else begin
      mtime_wr_val_s = {mtime_r[63:32], merge32(mtime_r[31:0], wdata_r, wstrb_r)};
    end
  end

  // mtime and prescaler; a software write overrides the tick and restarts
  // the prescaler so the written value lasts a full tick period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtime_r    <= 64'd0;
      prescale_r <= '0;
    end else if (mtime_wr_s) begin
      mtime_r    <= mtime_wr_val_s;
      prescale_r <= '0;
    end else if (tick_s) begin
      mtime_r    <= mtime_r + 64'd1;
      prescale_r <= '0;
    end else begin
      prescale_r <= prescale_r + PW'(1);
    end
  end
`else
  // mtime and prescaler; mtime is read-only, wraps silently at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtime_r    <= 64'd0;
      prescale_r <= '0;
    end else if (tick_s) begin
      mtime_r    <= mtime_r + 64'd1;
      prescale_r <= '0;
    end else begin
      prescale_r <= prescale_r + PW'(1);
    end
  end
`endif

  // mtimecmp: written one 32-bit half at a time; the intermediate value is
  // live, so software writes the high half to all-ones first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int h = 0; h < NHART; h++) begin
        mtimecmp_r[h] <= 64'hFFFF_FFFF_FFFF_FFFF;
      end
    end else if (wr_act_s && (wdec_s.kind == K_CMP)) begin
      if (wdec_s.hi) begin
        mtimecmp_r[wdec_s.hart][63:32] <=
          merge32(mtimecmp_r[wdec_s.hart][63:32], wdata_r, wstrb_r);
      end else begin
        mtimecmp_r[wdec_s.hart][31:0] <=
          merge32(mtimecmp_r[wdec_s.hart][31:0], wdata_r, wstrb_r);
      end
    end
  end

  // msip: only bit 0 of byte lane 0 is implemented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msip_r <= '0;
    end else if (wr_act_s && (wdec_s.kind == K_MSIP) && wstrb_r[0]) begin
      msip_r[wdec_s.hart] <= wdata_r[0];
    end
  end

  // Timer interrupt compare, registered (one cycle behind mtime/mtimecmp).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtip_r <= '0;
    end else begin
      for (int h = 0; h < NHART; h++) begin
        mtip_r[h] <= (mtime_r >= mtimecmp_r[h]);
      end
    end
  end

  assign axi_arready = arready_r;
  assign axi_rvalid  = rvalid_r;
  assign axi_rdata   = rdata_r;
  assign axi_rresp   = rresp_r;
  assign axi_rlast   = rvalid_r;
  assign axi_awready = awready_r;
  assign axi_wready  = wready_r;
  assign axi_bvalid  = bvalid_r;
  assign axi_bresp   = bresp_r;
  assign mtip        = mtip_r;
  assign msip        = msip_r;

endmodule

// File: tb/tb_ysyx_24100006_aclint.sv
module tb_ysyx_24100006_aclint;

  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam int          NH   = 2;

  logic          clk;
  logic          reset;
  logic [31:0]   araddr;
  logic          arvalid;
  logic          arready;
  logic          rvalid;
  logic          rready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic [31:0]   awaddr;
  logic          awvalid;
  logic          awready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          wvalid;
  logic          wready;
  logic          bvalid;
  logic          bready;
  logic [1:0]    bresp;
  logic [NH-1:0] mtip;
  logic [NH-1:0] msip;

  int total = 0;
  int bad   = 0;

  // Reference model: mtime counts clock edges since reset (TICK_DIV = 1).
  longint unsigned mtime_model;
  logic [NH-1:0]   msip_m;
  logic [63:0]     cmp_m [NH];

  ysyx_24100006_aclint #(
    .BASE_ADDR(BASE),
    .NHART    (NH),
    .TICK_DIV (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .axi_araddr (araddr),
    .axi_arvalid(arvalid),
    .axi_arready(arready),
    .axi_rvalid (rvalid),
    .axi_rready (rready),
    .axi_rdata  (rdata),
    .axi_rresp  (rresp),
    .axi_rlast  (rlast),
    .axi_awaddr (awaddr),
    .axi_awvalid(awvalid),
    .axi_awready(awready),
    .axi_wdata  (wdata),
    .axi_wstrb  (wstrb),
    .axi_wvalid (wvalid),
    .axi_wready (wready),
    .axi_bvalid (bvalid),
    .axi_bready (bready),
    .axi_bresp  (bresp),
    .mtip       (mtip),
    .msip       (msip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) mtime_model <= 64'd0;
    else       mtime_model <= mtime_model + 64'd1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // Expected read result from the register map rules.
  task automatic exp_read(input logic [31:0] addr, input longint unsigned mt,
                          output logic [31:0] d, output logic [1:0] r);
    logic [31:0] off;
    logic [63:0] mt64;
    int h;
    off  = addr - BASE;
    mt64 = mt;
    d = 32'd0;
    r = 2'b10;
    if (addr[1:0] == 2'b00) begin
      if (off < 32'h20) begin
        h = int'(off / 32'd4);
        if (h < NH) begin d = {31'd0, msip_m[h]}; r = 2'b00; end
      end else if (off >= 32'h4000 && off < 32'h4040) begin
        h = int'((off - 32'h4000) / 32'd8);
        if (h < NH) begin
          d = (off % 32'd8 == 32'd4) ? cmp_m[h][63:32] : cmp_m[h][31:0];
          r = 2'b00;
        end
      end else if (off == 32'hBFF8) begin
        d = mt64[31:0]; r = 2'b00;
      end else if (off == 32'hBFFC) begin
        d = mt64[63:32]; r = 2'b00;
      end
    end
  endtask

  // Apply a write to the model; returns the expected response.
  task automatic model_write(input logic [31:0] addr, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] r);
    logic [31:0] off;
    int h;
    off = addr - BASE;
    r = 2'b10;
    if (addr[1:0] == 2'b00) begin
      if (off < 32'h20) begin
        h = int'(off / 32'd4);
        if (h < NH) begin
          if (s[0]) msip_m[h] = d[0];
          r = 2'b00;
        end
      end else if (off >= 32'h4000 && off < 32'h4040) begin
        h = int'((off - 32'h4000) / 32'd8);
        if (h < NH) begin
          if (off % 32'd8 == 32'd4) cmp_m[h][63:32] = merge(cmp_m[h][63:32], d, s);
          else                      cmp_m[h][31:0]  = merge(cmp_m[h][31:0], d, s);
          r = 2'b00;
        end
      end else if (off == 32'hBFF8 || off == 32'hBFFC) begin
        r = 2'b00;
      end
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] d,
                          output logic [1:0] r, output logic l,
                          output longint unsigned mt_at);
    int n;
    logic ok;
    araddr  = addr;
    arvalid = 1'b1;
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin tick(); n++; if (arready) ok = 1'b1; end
    check("arready_seen", ok, 1);
    arvalid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin tick(); n++; if (rvalid) ok = 1'b1; end
    check("rvalid_seen", ok, 1);
    check("read_latency", n, 2);
    d     = rdata;
    r     = rresp;
    l     = rlast;
    mt_at = mtime_model - 64'd1;
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("rvalid_drop", {rvalid, rlast}, 2'b00);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] r);
    logic ok;
    awaddr  = addr;
    wdata   = d;
    wstrb   = s;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin tick(); if (awready && wready) ok = 1'b1; end
    check("awready_seen", ok, 1);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin tick(); if (bvalid) ok = 1'b1; end
    check("bvalid_seen", ok, 1);
    r = bresp;
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("bvalid_drop", bvalid, 0);
  endtask

  task automatic wr_chk(input string tag, input logic [31:0] addr,
                        input logic [31:0] d, input logic [3:0] s);
    logic [1:0] r, er;
    model_write(addr, d, s, er);
    axi_write(addr, d, s, r);
    check(tag, r, er);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr);
    logic [31:0] d, ed;
    logic [1:0]  r, er;
    logic        l;
    longint unsigned mt;
    axi_read(addr, d, r, l, mt);
    exp_read(addr, mt, ed, er);
    check({tag, "_rresp"}, r, er);
    check({tag, "_rdata"}, d, ed);
    check({tag, "_rlast"}, l, 1);
  endtask

  task automatic check_irq(input string tag);
    logic [NH-1:0] em;
    for (int h = 0; h < NH; h++) em[h] = ((mtime_model - 64'd1) >= cmp_m[h]);
    check({tag, "_mtip"}, mtip, em);
    check({tag, "_msip"}, msip, msip_m);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    arvalid = 1'b0; araddr = 32'd0; rready = 1'b0;
    awvalid = 1'b0; awaddr = 32'd0; wvalid = 1'b0; wdata = 32'd0; wstrb = 4'd0;
    bready  = 1'b0;
    repeat (3) tick();
    check("rst_handshake", {arready, awready, wready, rvalid, rlast, bvalid}, 6'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_resp", {rresp, bresp}, 4'd0);
    check("rst_irq", {mtip, msip}, '0);
    reset = 1'b0;
    msip_m = '0;
    for (int h = 0; h < NH; h++) cmp_m[h] = 64'hFFFF_FFFF_FFFF_FFFF;
  endtask

  initial begin
    logic [31:0] d, lo;
    logic [1:0]  r;
    logic        l, ok;
    longint unsigned mt;
    logic [31:0] offs [13];
    int op, idx;

    offs = '{32'h0000, 32'h0004, 32'h0008, 32'h4000, 32'h4004, 32'h4008,
             32'h400C, 32'h4010, 32'h8000, 32'h0002, 32'hFFFF_FFFC,
             32'hBFF8, 32'hBFFC};

    // Idle count-up and reset contents.
    do_reset();
    repeat (10) tick();
    axi_read(BASE + 32'hBFF8, d, r, l, mt);
    check("mtime_idle_exact", d, mt);
    check("mtime_idle_range", (d >= 32'd9 && d <= 32'd11), 1);
    check("mtime_idle_rresp", r, 2'b00);
    check("mtime_idle_rlast", l, 1);
    rd_chk("cmp0_lo_rst", BASE + 32'h4000);
    rd_chk("cmp1_hi_rst", BASE + 32'h400C);
    rd_chk("mtime_hi", BASE + 32'hBFFC);

    // mtip edge at mtime == 50 (checked cycle by cycle against the model).
    do_reset();
    wr_chk("cmp0_hi_w", BASE + 32'h4004, 32'd0, 4'hF);
    wr_chk("cmp0_lo_w", BASE + 32'h4000, 32'd50, 4'hF);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      check_irq("mtip_edge");
      if (mtime_model >= 64'd56) ok = 1'b1;
    end
    check("mtip_edge_done", ok, 1);
    check("mtip_high_now", mtip[0], 1);
    wr_chk("cmp0_lo_ones", BASE + 32'h4000, 32'hFFFF_FFFF, 4'hF);
    check_irq("mtip_clear");
    check("mtip_low_now", mtip[0], 0);

    // msip for hart 1, strobe-less write.
    wr_chk("msip1_w", BASE + 32'h0004, 32'd1, 4'hF);
    check("msip_10", msip, 2'b10);
    rd_chk("msip1_r", BASE + 32'h0004);
    wr_chk("msip0_nostrb", BASE + 32'h0000, 32'd1, 4'h0);
    check("msip_unchanged", msip, 2'b10);

    // Error responses.
    rd_chk("err_8000", BASE + 32'h8000);
    rd_chk("err_0002", BASE + 32'h0002);
    wr_chk("err_w0008", BASE + 32'h0008, 32'd1, 4'hF);
    check_irq("after_err");

    // Read/write tie: read first, rvalid held while rready is low.
    araddr = BASE + 32'h4000; arvalid = 1'b1;
    awaddr = BASE + 32'h0000; wdata = 32'd1; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    check("tie_read_first", {arready, awready, wready}, 3'b100);
    arvalid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("tie_rvalid_hold", {rvalid, rlast}, 2'b11);
      check("tie_rdata_hold", rdata, cmp_m[0][31:0]);
      tick();
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("tie_rvalid_drop", rvalid, 0);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin tick(); if (awready && wready) ok = 1'b1; end
    check("tie_write_next", ok, 1);
    awvalid = 1'b0; wvalid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin tick(); if (bvalid) ok = 1'b1; end
    check("tie_bvalid", ok, 1);
    check("tie_bresp", bresp, 2'b00);
    bready = 1'b1; tick(); bready = 1'b0;
    msip_m[0] = 1'b1;
    check("tie_msip", msip, 2'b11);

    // mtime writes.
`ifdef CLINT_MTIME_WR_EN
    wr_chk("cmp0_lo_50", BASE + 32'h4000, 32'd50, 4'hF);
    check_irq("pre_wrap");
    check("pre_wrap_mtip", mtip[0], 1);
    axi_write(BASE + 32'hBFFC, 32'hFFFF_FFFF, 4'hF, r);
    check("mtime_hi_w_bresp", r, 2'b00);
    axi_write(BASE + 32'hBFF8, 32'hFFFF_FFFF, 4'hF, r);
    check("mtime_lo_w_bresp", r, 2'b00);
    tick();
    check("wrap_mtip_drop", mtip[0], 0);
    axi_read(BASE + 32'hBFFC, d, r, l, mt);
    check("wrap_hi", d, 32'd0);
    axi_read(BASE + 32'hBFF8, d, r, l, mt);
    check("wrap_lo_small", (d < 32'd16), 1);
`else
    axi_write(BASE + 32'hBFF8, 32'hFFFF_FFFF, 4'hF, r);
    check("mtime_w_okay", r, 2'b00);
    rd_chk("mtime_keeps_lo", BASE + 32'hBFF8);
    rd_chk("mtime_keeps_hi", BASE + 32'hBFFC);
`endif

    // Reset in the middle of a write.
    awaddr = BASE + 32'h0004; wdata = 32'd1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin tick(); if (awready) ok = 1'b1; end
    check("mid_awready", ok, 1);
    reset = 1'b1; awvalid = 1'b0; wvalid = 1'b0;
    #1;
    check("mid_rst_outputs", {awready, wready, bvalid, rvalid, msip, mtip}, '0);
    do_reset();
    tick();
    check_irq("mid_rst_lost");

    // Randomized traffic against the model.
    for (int it = 0; it < 60; it++) begin
      op = int'($urandom_range(0, 3));
      case (op)
        0: begin
          idx = int'($urandom_range(0, 10));
          wr_chk("rnd_w", BASE + offs[idx], $urandom, 4'($urandom_range(0, 15)));
        end
        1: begin
          idx = int'($urandom_range(0, 12));
          rd_chk("rnd_r", BASE + offs[idx]);
        end
        2: begin
          idx = int'($urandom_range(0, NH - 1));
          lo = 32'(mtime_model) + 32'($urandom_range(0, 40)) - 32'd10;
          wr_chk("rnd_cmp_hi", BASE + 32'h4004 + 32'(idx * 8), 32'd0, 4'hF);
          wr_chk("rnd_cmp_lo", BASE + 32'h4000 + 32'(idx * 8), lo, 4'hF);
        end
        default: begin
          repeat ($urandom_range(0, 5)) tick();
        end
      endcase
      tick();
      check_irq("rnd_irq");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
